a_matrix_mac: RTL and testbench
===============================

Name: a_matrix_mac

Overview:
- Downstream consumer of the A-matrix column reader; computes y = A·x for one channel.
- On start, latches a 25-element feature vector x, then requests the 25 A columns one at a time.
- Each returned column (A[0..24][k]) is multiplied by x[k] and accumulated into 25 parallel signed accumulators.
- After column 24, emits the rescaled, saturated 25-element result vector to the next stage.

Parameters:
N, 25, vector length / column count (fixed pairing with the reader's 25-deep address wrap)
DATA_W, 16, signed element width of A, x and y
FRAC, 8, fractional bits of the fixed-point format (Q7.8)
ACC_W, 40, signed accumulator width
GAP, 4, minimum cycles between successive need_data pulses

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle job start; ignored while busy=1
x_vec  in  N*DATA_W  feature vector, element k at bits [16k+15:16k]; sampled only with accepted start
need_data  out  1  one-cycle column request to the A-matrix reader
a_v  in  1  column valid from the reader
a_col  in  N*DATA_W  column k, lane i = A[i][k] at bits [16i+15:16i]
busy  out  1  job in progress
out_v  out  1  one-cycle result valid
out_vec  out  N*DATA_W  result y, lane i at bits [16i+15:16i]; held until next out_v
err  out  1  sticky: a_v received outside WAIT; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, col=0, accumulators=0, x register=0, need_data=0, busy=0, out_v=0, out_vec=0, err=0. The reader shares rst, so its address realigns at the same time. Aborting mid-job discards the partial result.
- States and transitions:
  - IDLE: on start=1, latch x_vec, clear accumulators, col=0 -> REQ.
  - REQ: need_data=1 for exactly this cycle; start gap counter -> WAIT.
  - WAIT: on a_v=1, acc[i] += a_col[i]*x[col] for all i, signed 16x16 -> 32-bit product sign-extended to ACC_W. If col==N-1 -> OUT; else col++ -> GAP.
  - GAP: hold until GAP cycles have elapsed since the last REQ cycle -> REQ. The next REQ is at max(REQ+GAP, accept+1).
  - OUT: lane i = saturate(acc[i] >>> FRAC) into [-32768, 32767]; register it into out_vec with out_v=1 next cycle -> IDLE.
- Nominal timing with the reader at 2-cycle latency and start high in cycle 0:
  - need_data high in cycles 1, 5, ..., 97.
  - a_v accepted in cycles 3, 7, ..., 99.
  - out_v high in cycle 101 only.
  - busy high in cycles 1..101.
- a_v latency is not fixed: WAIT waits indefinitely.
- need_data is never reissued fewer than GAP cycles after the previous one. The reader needs this to advance its address.
- Exactly N requests are issued per job, which keeps the reader's wrap-around address aligned across jobs.
- a_v in any state other than WAIT: ignored for arithmetic, sets err=1.
- start during busy: ignored. start in the same cycle as out_v: ignored, because busy is still 1.
- Shift is arithmetic (round toward −∞). Saturation is applied after the shift. Accumulators never overflow at 40 bits (25·2^30 < 2^39).

Test Plan:
- All A=0x0100, all x=0x0100, reader at 2-cycle latency -> every out lane 0x1900 (25.0). out_v in cycle 101, need_data pulses exactly 4 cycles apart, 25 pulses.
- A=0x7FFF everywhere, x=0x7FFF -> all lanes 0x7FFF. Same with x=0x8001 -> all lanes 0x8000. err=0.
- A column k lane i = i+k (raw), x[k]=0x0100 only for k=3, else 0 -> lane i = i+3. Checks lane/column ordering.
- Reader returns a_v 6 cycles after each need_data -> identical result to the nominal case; need_data spacing is 7 cycles.
- start pulsed at cycle 40 of a running job, and a stray a_v while IDLE -> the job result is unaffected, only one out_v, err=1 after the stray a_v.
- rst asserted at cycle 50 mid-job -> need_data, busy and out_v drop immediately, out_vec=0. After release, a new start completes with the correct result.

Source files
------------

// File: rtl/a_matrix_mac.sv
// rtl/a_matrix_mac.sv - y = A*x over 25 streamed A columns, Q7.8 rescale with saturation
module a_matrix_mac #(
    parameter int N      = 25,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int GAP    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*DATA_W-1:0] x_vec,
    output logic                need_data,
    input  logic                a_v,
    input  logic [N*DATA_W-1:0] a_col,
    output logic                busy,
    output logic                out_v,
    output logic [N*DATA_W-1:0] out_vec,
    output logic                err
);

    localparam int COL_W  = $clog2(N);
    localparam int PROD_W = 2 * DATA_W;
    localparam int GCNT_W = $clog2(GAP) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0]                 state;
    logic [COL_W-1:0]           col;
    logic [GCNT_W-1:0]          gcnt;
    logic [N*DATA_W-1:0]        x_reg;
    logic signed [ACC_W-1:0]    acc     [N];
    logic signed [ACC_W-1:0]    shifted [N];
    logic signed [PROD_W-1:0]   prod    [N];
    logic signed [DATA_W-1:0]   x_sel;
    logic [N*DATA_W-1:0]        sat_vec;
    logic                       gap_done;

    assign x_sel     = x_reg[col*DATA_W +: DATA_W];
    assign need_data = (state == S_REQ);
    // out_v is issued from IDLE, so busy must cover that cycle too
    assign busy      = (state != S_IDLE) || out_v;
    // gcnt holds cycles elapsed since the last request cycle
    assign gap_done  = (gcnt >= GCNT_W'(GAP - 1));

    always_comb begin
        sat_vec = '0;
        for (int i = 0; i < N; i++) begin
            prod[i]    = $signed(a_col[i*DATA_W +: DATA_W]) * x_sel;
            shifted[i] = acc[i] >>> FRAC;
            if (shifted[i] > SAT_MAX)
                sat_vec[i*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            else if (shifted[i] < SAT_MIN)
                sat_vec[i*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            else
                sat_vec[i*DATA_W +: DATA_W] = shifted[i][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            col     <= '0;
            gcnt    <= '0;
            x_reg   <= '0;
            out_v   <= 1'b0;
            out_vec <= '0;
            err     <= 1'b0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else begin
            out_v <= 1'b0;
            if (a_v && (state != S_WAIT))
                err <= 1'b1;
            if (state == S_REQ)
                gcnt <= GCNT_W'(1);
            else if (gcnt != '1)
                gcnt <= gcnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start && !out_v) begin
                        x_reg <= x_vec;
                        col   <= '0;
                        for (int i = 0; i < N; i++) acc[i] <= '0;
                        state <= S_REQ;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (a_v) begin
                        for (int i = 0; i < N; i++)
                            acc[i] <= acc[i] + ACC_W'(prod[i]);
                        if (col == COL_W'(N - 1)) begin
                            state <= S_OUT;
                        end else begin
                            col   <= col + 1'b1;
                            // a late column may already satisfy the spacing rule
                            state <= gap_done ? S_REQ : S_GAP;
                        end
                    end
                end
                S_GAP: if (gap_done) state <= S_REQ;
                S_OUT: begin
                    out_vec <= sat_vec;
                    out_v   <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_matrix_mac.sv
// tb/tb_a_matrix_mac.sv - directed and randomized jobs against an arithmetic y = A*x model
module tb_a_matrix_mac;
    localparam int N  = 25;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              a_v = 1'b0;
    logic [N*DW-1:0]   x_vec = '0;
    logic [N*DW-1:0]   a_col = '0;
    logic              need_data, busy, out_v, err;
    logic [N*DW-1:0]   out_vec;

    a_matrix_mac dut (
        .clk(clk), .rst(rst), .start(start), .x_vec(x_vec), .need_data(need_data),
        .a_v(a_v), .a_col(a_col), .busy(busy), .out_v(out_v), .out_vec(out_vec), .err(err)
    );

    always #5 clk = ~clk;

    int      ncmp = 0;
    int      nfail = 0;
    shortint amat [N][N];
    shortint xv   [N];
    logic    err_exp = 1'b0;

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] model_y();
        logic [N*DW-1:0] y;
        longint s;
        y = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += longint'(amat[i][k]) * longint'(xv[k]);
            s = s >>> 8;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            y[i*DW +: DW] = 16'(s);
        end
        return y;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                case (mode)
                    0: amat[i][k] = 16'sh0100;
                    1: amat[i][k] = 16'sh7FFF;
                    2: amat[i][k] = shortint'(i + k);
                    default: amat[i][k] = shortint'($urandom);
                endcase
    endtask

    // Reader model: returns column k (job-relative) lat cycles after each need_data.
    task automatic run_job(input int lat, input int start2, input int abort_at);
        int c, k, nreq, last_req, min_sp, max_sp, busy_cnt, out_cyc, r, acc_c, exp_out, sp, extra;
        int due[$];
        logic [N*DW-1:0] y_exp;
        y_exp = model_y();
        r = 1;
        acc_c = 0;
        for (int j = 0; j < N; j++) begin
            acc_c = r + lat;
            r = (r + 4 > acc_c + 1) ? r + 4 : acc_c + 1;
        end
        exp_out = acc_c + 2;
        sp = (lat + 1 > 4) ? lat + 1 : 4;
        for (int q = 0; q < N; q++) x_vec[q*DW +: DW] = xv[q];
        k = 0; nreq = 0; last_req = -1; min_sp = 1000; max_sp = 0; busy_cnt = 0; out_cyc = -1;
        for (c = 0; c < 400 && out_cyc < 0; c++) begin
            start = (c == 0) || (c == start2);
            if (c == start2) x_vec = ~x_vec;
            a_v = 1'b0;
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                a_v = 1'b1;
                for (int i = 0; i < N; i++) a_col[i*DW +: DW] = amat[i][k];
                k++;
            end
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                err_exp = 1'b0;
                chk("abort_need_data", {{(N*DW-1){1'b0}}, need_data}, '0);
                chk("abort_busy", {{(N*DW-1){1'b0}}, busy}, '0);
                chk("abort_out_v", {{(N*DW-1){1'b0}}, out_v}, '0);
                chk("abort_out_vec", out_vec, '0);
                chk("abort_err", {{(N*DW-1){1'b0}}, err}, '0);
                start = 1'b0;
                a_v = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (need_data) begin
                nreq++;
                if (last_req >= 0) begin
                    if (c - last_req < min_sp) min_sp = c - last_req;
                    if (c - last_req > max_sp) max_sp = c - last_req;
                end
                last_req = c;
                due.push_back(c + lat);
            end
            if (busy) busy_cnt++;
            if (out_v) out_cyc = c;
            @(posedge clk); #1;
        end
        start = 1'b0;
        a_v = 1'b0;
        chk_i("out_cycle", out_cyc, exp_out);
        chk_i("req_count", nreq, N);
        chk_i("min_spacing", min_sp, sp);
        chk_i("max_spacing", max_sp, sp);
        chk_i("busy_cycles", busy_cnt, exp_out);
        chk("out_vec", out_vec, y_exp);
        chk("busy_after", {{(N*DW-1){1'b0}}, busy}, '0);
        chk("err_job", {{(N*DW-1){1'b0}}, err}, {{(N*DW-1){1'b0}}, err_exp});
        extra = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (out_v) extra++;
            @(posedge clk); #1;
        end
        chk_i("extra_out_v", extra, 0);
        chk("out_vec_held", out_vec, y_exp);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_need_data", {{(N*DW-1){1'b0}}, need_data}, '0);
        chk("rst_busy", {{(N*DW-1){1'b0}}, busy}, '0);
        chk("rst_out_v", {{(N*DW-1){1'b0}}, out_v}, '0);
        chk("rst_out_vec", out_vec, '0);
        chk("rst_err", {{(N*DW-1){1'b0}}, err}, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        fill(0);
        for (int k = 0; k < N; k++) xv[k] = 16'sh0100;
        run_job(2, -1, -1);
        chk("nominal_lane0", {{(N*DW-DW){1'b0}}, out_vec[DW-1:0]}, {{(N*DW-DW){1'b0}}, 16'h1900});

        fill(1);
        for (int k = 0; k < N; k++) xv[k] = 16'sh7FFF;
        run_job(2, -1, -1);
        for (int k = 0; k < N; k++) xv[k] = -16'sh7FFF;
        run_job(2, -1, -1);

        fill(2);
        for (int k = 0; k < N; k++) xv[k] = (k == 3) ? 16'sh0100 : 16'sh0000;
        run_job(2, -1, -1);

        fill(0);
        for (int k = 0; k < N; k++) xv[k] = 16'sh0100;
        run_job(6, -1, -1);

        for (int j = 0; j < 3; j++) begin
            fill(3);
            for (int k = 0; k < N; k++) xv[k] = shortint'($urandom);
            run_job(int'($urandom_range(1, 8)), -1, -1);
        end

        fill(3);
        for (int k = 0; k < N; k++) xv[k] = shortint'($urandom_range(0, 1023)) - 16'sd512;
        run_job(2, 40, -1);
        a_v = 1'b1;
        a_col = {N{16'h1234}};
        @(posedge clk); #1;
        a_v = 1'b0;
        err_exp = 1'b1;
        @(negedge clk);
        chk("stray_err", {{(N*DW-1){1'b0}}, err}, {{(N*DW-1){1'b0}}, err_exp});
        @(posedge clk); #1;
        run_job(3, -1, -1);

        run_job(2, -1, 50);
        fill(3);
        for (int k = 0; k < N; k++) xv[k] = shortint'($urandom);
        run_job(2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
